// File: rtl/shift_subtract_divider.sv
// Sequential restoring (shift-subtract) unsigned divider, one quotient bit per clock.
// Optional macro SSDIV_DIV0_FAST_EN: divide-by-zero skips iteration and raises div_by_zero_o.
module shift_subtract_divider #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   remo_q, remo_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic               fits;
    logic [WIDTH-1:0]   quo_next;
    logic [WIDTH-1:0]   rem_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;

        // Trial subtract; the sign bit of the (WIDTH+1)-bit difference decides the quotient bit.
        // The kept remainder is always below the divisor, so WIDTH bits of storage suffice.
        shifted  = {rem_q, quo_q[WIDTH-1]};
        trial    = shifted - {1'b0, dvs_q};
        fits     = ~trial[WIDTH];
        quo_next = {quo_q[WIDTH-2:0], fits};
        rem_next = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    quo_d   = dividend_i;
                    dvs_d   = divisor_i;
                    rem_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    busy_d  = 1'b1;
                    dbz_d   = 1'b0;
                    state_d = RUN;
`ifdef SSDIV_DIV0_FAST_EN
                    if (divisor_i == '0) begin
                        cnt_d   = '0;
                        quot_d  = '1;
                        remo_d  = dividend_i;
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
`endif
                end
            end
            RUN: begin
                rem_d = rem_next;
                quo_d = quo_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    quot_d  = quo_next;
                    remo_d  = rem_next;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign quotient_o    = quot_q;
    assign remainder_o   = remo_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_shift_subtract_divider.sv
// Self-checking bench for shift_subtract_divider: WIDTH=4 vector table and corner sequences,
// WIDTH=8 random sweep against a plain-arithmetic division model.
module tb_shift_subtract_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s4, s8;
    logic [3:0] a4, b4, q4, r4;
    logic [7:0] a8, b8, q8, r8;
    logic       busy4, done4, z4, busy8, done8, z8;

    int errors = 0;
    int checks = 0;
    int dn4 = 0;
    int dn8 = 0;

    always #5 clk = ~clk;

    shift_subtract_divider #(.WIDTH(4)) u_div4 (
        .clk(clk), .rst_n(rst_n), .start_i(s4), .dividend_i(a4), .divisor_i(b4),
        .busy_o(busy4), .done_o(done4), .quotient_o(q4), .remainder_o(r4), .div_by_zero_o(z4)
    );

    shift_subtract_divider #(.WIDTH(8)) u_div8 (
        .clk(clk), .rst_n(rst_n), .start_i(s8), .dividend_i(a8), .divisor_i(b8),
        .busy_o(busy8), .done_o(done8), .quotient_o(q8), .remainder_o(r8), .div_by_zero_o(z8)
    );

    // Done pulses, counted from the value held just before each edge.
    always @(posedge clk) begin
        if (done4) dn4 <= dn4 + 1;
        if (done8) dn8 <= dn8 + 1;
    end

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void model(input int w, input int a, input int b, output int q, output int r);
        if (b == 0) begin
            q = (1 << w) - 1;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic int exp_lat(input int w, input int b);
`ifdef SSDIV_DIV0_FAST_EN
        return (b == 0) ? 0 : w;
`else
        return w + 0 * b;
`endif
    endfunction

    function automatic logic exp_z(input int b);
`ifdef SSDIV_DIV0_FAST_EN
        return (b == 0);
`else
        return 1'b0 && (b == 0);
`endif
    endfunction

    function automatic logic [7:0] cur_q(input int w);
        return (w == 4) ? {4'b0, q4} : q8;
    endfunction
    function automatic logic [7:0] cur_r(input int w);
        return (w == 4) ? {4'b0, r4} : r8;
    endfunction
    function automatic logic cur_busy(input int w);
        return (w == 4) ? busy4 : busy8;
    endfunction
    function automatic logic cur_done(input int w);
        return (w == 4) ? done4 : done8;
    endfunction
    function automatic logic cur_z(input int w);
        return (w == 4) ? z4 : z8;
    endfunction
    function automatic int cur_dn(input int w);
        return (w == 4) ? dn4 : dn8;
    endfunction

    // One operation: start for one edge, measure edges until done, check results and handshake.
    task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er);
        int lat;
        int d0;
        @(negedge clk);
        d0 = cur_dn(w);
        if (w == 4) begin a4 = a[3:0]; b4 = b[3:0]; s4 = 1'b1; end
        else        begin a8 = a;      b8 = b;      s8 = 1'b1; end
        @(posedge clk);
        @(negedge clk);
        s4 = 1'b0; s8 = 1'b0;
        a4 = ~a4; b4 = ~b4; a8 = ~a8; b8 = ~b8;
        chk("busy_after_start", 64'(cur_busy(w)), 64'(1));
        lat = 0;
        while (!cur_done(w) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(exp_lat(w, int'(b))));
        chk("quotient", 64'(cur_q(w)), 64'(eq));
        chk("remainder", 64'(cur_r(w)), 64'(er));
        chk("div_by_zero", 64'(cur_z(w)), 64'(exp_z(int'(b))));
        @(negedge clk);
        chk("busy_clear", 64'(cur_busy(w)), 64'(0));
        chk("done_one_cycle", 64'(cur_done(w)), 64'(0));
        @(negedge clk);
        chk("done_count", 64'(cur_dn(w) - d0), 64'(1));
        chk("quotient_held", 64'(cur_q(w)), 64'(eq));
        chk("remainder_held", 64'(cur_r(w)), 64'(er));
    endtask

    initial begin
        int d0;
        int eq, er;
        logic [7:0] ra, rb;

        tbl[0] = '{a: 4'd13, b: 4'd3,  q: 4'd4,  r: 4'd1};
        tbl[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0};
        tbl[2] = '{a: 4'd7,  b: 4'd9,  q: 4'd0,  r: 4'd7};
        tbl[3] = '{a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0};
        tbl[4] = '{a: 4'd9,  b: 4'd0,  q: 4'd15, r: 4'd9};
        tbl[5] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0};
        tbl[6] = '{a: 4'd14, b: 4'd4,  q: 4'd3,  r: 4'd2};
        tbl[7] = '{a: 4'd1,  b: 4'd15, q: 4'd0,  r: 4'd1};

        rst_n = 1'b0;
        s4 = 1'b0; s8 = 1'b0;
        a4 = '0; b4 = '0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy4), 64'(0));
        chk("rst_done", 64'(done4), 64'(0));
        chk("rst_quotient", 64'(q4), 64'(0));
        chk("rst_remainder", 64'(r4), 64'(0));
        chk("rst_div_by_zero", 64'(z4), 64'(0));
        chk("rst_quotient8", 64'(q8), 64'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run_op(4, {4'b0, tbl[i].a}, {4'b0, tbl[i].b}, {4'b0, tbl[i].q}, {4'b0, tbl[i].r});

        // Start pulsed mid-run with other operands: must be ignored.
        @(negedge clk);
        d0 = dn4;
        a4 = 4'd13; b4 = 4'd3; s4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s4 = 1'b0;
        @(negedge clk);
        a4 = 4'd6; b4 = 4'd2; s4 = 1'b1;
        @(negedge clk);
        s4 = 1'b0; a4 = '0; b4 = '0;
        repeat (8) @(negedge clk);
        chk("ignore_done_count", 64'(dn4 - d0), 64'(1));
        chk("ignore_quotient", 64'(q4), 64'(4));
        chk("ignore_remainder", 64'(r4), 64'(1));
        chk("ignore_busy", 64'(busy4), 64'(0));

        // Reset for one edge in the middle of a run.
        @(negedge clk);
        d0 = dn4;
        a4 = 4'd13; b4 = 4'd3; s4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s4 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_busy", 64'(busy4), 64'(0));
        chk("midrst_done", 64'(done4), 64'(0));
        chk("midrst_quotient", 64'(q4), 64'(0));
        chk("midrst_remainder", 64'(r4), 64'(0));
        chk("midrst_div_by_zero", 64'(z4), 64'(0));
        repeat (6) @(negedge clk);
        chk("midrst_no_done", 64'(dn4 - d0), 64'(0));
        run_op(4, 8'd10, 8'd3, 8'd3, 8'd1);

        // Start held high across two operations.
        @(negedge clk);
        d0 = dn4;
        a4 = 4'd13; b4 = 4'd3; s4 = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        s4 = 1'b0;
        repeat (10) @(negedge clk);
        chk("held_start_done_count", 64'(dn4 - d0), 64'(2));
        chk("held_start_quotient", 64'(q4), 64'(4));
        chk("held_start_busy", 64'(busy4), 64'(0));

        run_op(8, 8'd255, 8'd16, 8'd15, 8'd15);
        run_op(8, 8'd255, 8'd255, 8'd1, 8'd0);
        run_op(8, 8'd200, 8'd0, 8'd255, 8'd200);

        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = (i % 16 == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            model(8, int'(ra), int'(rb), eq, er);
            run_op(8, ra, rb, 8'(eq), 8'(er));
            if (rb != 8'd0) begin
                chk("invariant", 64'(16'(q8) * 16'(rb) + 16'(r8)), 64'(ra));
                chk("rem_below_divisor", 64'(r8 < rb), 64'(1));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
